icache: RTL and testbench

Direct-mapped, read-only instruction cache that answers the fetch addresses driven by the datapath's program counter and returns the instruction word with a hit strobe. It sits between the datapath's instruction port and the memory controller's instruction port. On a miss it issues a single-word read to memory, fills the line, and then answers the still-pending request as a hit. It also keeps hit/miss counters for performance reporting.

---
 rtl/icache.sv | 91 +++++++++
 tb/tb_icache.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with single-word fill and hit/miss counters
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dp_iREN,
    input  logic [31:0] dp_imemaddr,
    output logic        dp_ihit,
    output logic [31:0] dp_imemload,
    output logic        mem_iREN,
    output logic [31:0] mem_iaddr,
    input  logic        mem_iwait,
    input  logic [31:0] mem_iload,
    input  logic        inv,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t          state, next_state;
    logic [SETS-1:0] valid;
    logic [TW-1:0]   tags [SETS];
    logic [31:0]     data [SETS];
    logic [31:0]     miss_addr;

    logic [IW-1:0] idx, fill_idx;
    logic [TW-1:0] tag;
    logic          lookup, hit, miss, fill_done;
    logic          unused_addr_bits;

    assign idx              = dp_imemaddr[IW+1:2];
    assign tag              = dp_imemaddr[31:IW+2];
    assign fill_idx         = miss_addr[IW+1:2];
    assign unused_addr_bits = ^dp_imemaddr[1:0];

    // inv suppresses both hit and miss so nothing is counted that cycle
    assign lookup    = (state == IDLE) && dp_iREN && !inv;
    assign hit       = lookup && valid[idx] && (tags[idx] == tag);
    assign miss      = lookup && !hit;
    assign fill_done = (state == FETCH) && !mem_iwait;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (miss)      next_state = FETCH;
            FETCH:   if (!mem_iwait) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        dp_ihit     = hit;
        dp_imemload = hit ? data[idx] : 32'd0;
        mem_iREN    = (state == FETCH);
        mem_iaddr   = (state == FETCH) ? miss_addr : 32'd0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid      <= '0;
            miss_addr  <= 32'd0;
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            // inv has priority over a completing fill: the filled line is dropped
            if (inv)            valid           <= '0;
            else if (fill_done) valid[fill_idx] <= 1'b1;
            if (miss) begin
                miss_addr  <= {dp_imemaddr[31:2], 2'b00};
                miss_count <= miss_count + 32'd1;
            end
            if (hit) hit_count <= hit_count + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[fill_idx] <= miss_addr[31:IW+2];
            data[fill_idx] <= mem_iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        dp_iREN;
    logic [31:0] dp_imemaddr;
    logic        dp_ihit;
    logic [31:0] dp_imemload;
    logic        mem_iREN;
    logic [31:0] mem_iaddr;
    logic        mem_iwait;
    logic [31:0] mem_iload;
    logic        inv;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int total = 0;
    int bad   = 0;
    int e_hit = 0;
    int e_miss = 0;

    icache #(.SETS(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .dp_iREN(dp_iREN), .dp_imemaddr(dp_imemaddr),
        .dp_ihit(dp_ihit), .dp_imemload(dp_imemload),
        .mem_iREN(mem_iREN), .mem_iaddr(mem_iaddr),
        .mem_iwait(mem_iwait), .mem_iload(mem_iload),
        .inv(inv), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic hit_tick();
        tick();
        e_hit++;
    endtask

    // Miss on addr, serve it after `waits` busy cycles, then see the hit
    task automatic fill(input logic [31:0] addr, input logic [31:0] word, input int waits);
        logic [31:0] wa;
        wa = {addr[31:2], 2'b00};
        dp_iREN = 1'b1;
        dp_imemaddr = addr;
        #1;
        chk("miss_ihit", {31'd0, dp_ihit}, 32'd0);
        chk("miss_memren", {31'd0, mem_iREN}, 32'd0);
        tick();
        e_miss++;
        for (int i = 0; i < waits; i++) begin
            mem_iwait = 1'b1;
            #1;
            chk("wait_memren", {31'd0, mem_iREN}, 32'd1);
            chk("wait_iaddr", mem_iaddr, wa);
            tick();
        end
        mem_iwait = 1'b0;
        mem_iload = word;
        #1;
        chk("done_memren", {31'd0, mem_iREN}, 32'd1);
        chk("done_iaddr", mem_iaddr, wa);
        tick();
        mem_iwait = 1'b1;
        mem_iload = 32'd0;
        #1;
        chk("after_fill_ihit", {31'd0, dp_ihit}, 32'd1);
        chk("after_fill_data", dp_imemload, word);
    endtask

    task automatic counters(input string tag);
        chk({tag, "_hits"}, hit_count, e_hit);
        chk({tag, "_misses"}, miss_count, e_miss);
    endtask

    initial begin
        logic [31:0] addrs [3];
        logic [31:0] words [3];
        addrs = '{32'h0, 32'h4, 32'h8};
        words = '{32'hAAAA0000, 32'h11110004, 32'h22220008};

        nRST = 1'b0; dp_iREN = 1'b0; dp_imemaddr = 32'd0;
        mem_iwait = 1'b1; mem_iload = 32'd0; inv = 1'b0;
        #1;
        chk("rst_ihit", {31'd0, dp_ihit}, 32'd0);
        chk("rst_load", dp_imemload, 32'd0);
        chk("rst_memren", {31'd0, mem_iREN}, 32'd0);
        chk("rst_iaddr", mem_iaddr, 32'd0);
        counters("rst");
        tick(); tick();
        nRST = 1'b1;
        tick();

        // cold miss with two wait cycles
        fill(32'h40, 32'h8C220004, 2);
        hit_tick();
        dp_iREN = 1'b0;
        #1;
        chk("cold_hits", hit_count, 32'd1);
        chk("cold_misses", miss_count, 32'd1);
        chk("idle_iaddr", mem_iaddr, 32'd0);

        // low address bits ignored
        dp_iREN = 1'b1; dp_imemaddr = 32'h43;
        #1;
        chk("unal_ihit", {31'd0, dp_ihit}, 32'd1);
        chk("unal_data", dp_imemload, 32'h8C220004);
        hit_tick();

        for (int i = 0; i < 3; i++) begin
            fill(addrs[i], words[i], 0);
            hit_tick();
        end
        for (int i = 0; i < 3; i++) begin
            dp_imemaddr = addrs[i];
            #1;
            chk("b2b_ihit", {31'd0, dp_ihit}, 32'd1);
            chk("b2b_data", dp_imemload, words[i]);
            chk("b2b_memren", {31'd0, mem_iREN}, 32'd0);
            hit_tick();
        end
        chk("b2b_hits", hit_count, 32'd8);

        // 0x40 was evicted by 0x0 (index 0), and vice versa
        fill(32'h40, 32'h8C220004, 1);
        hit_tick();
        fill(32'h0, 32'hAAAA0000, 0);
        hit_tick();
        counters("conflict");

        // invalidate masks a would-be hit and counts nothing
        dp_imemaddr = 32'h4; inv = 1'b1;
        #1;
        chk("inv_ihit", {31'd0, dp_ihit}, 32'd0);
        chk("inv_memren", {31'd0, mem_iREN}, 32'd0);
        tick();
        inv = 1'b0;
        fill(32'h0, 32'hAAAA0000, 0); hit_tick();
        fill(32'h4, 32'h11110004, 0); hit_tick();
        fill(32'h8, 32'h22220008, 0); hit_tick();
        fill(32'h40, 32'h8C220004, 0); hit_tick();
        counters("inv");

        // inv coincident with fill completion discards the line
        dp_imemaddr = 32'hC;
        #1;
        chk("invfill_miss", {31'd0, dp_ihit}, 32'd0);
        tick(); e_miss++;
        mem_iwait = 1'b0; mem_iload = 32'h33333333; inv = 1'b1;
        #1;
        chk("invfill_memren", {31'd0, mem_iREN}, 32'd1);
        tick();
        inv = 1'b0; mem_iwait = 1'b1;
        #1;
        chk("invfill_remiss", {31'd0, dp_ihit}, 32'd0);
        chk("invfill_idle", {31'd0, mem_iREN}, 32'd0);
        tick(); e_miss++;
        chk("refetch_iaddr", mem_iaddr, 32'hC);
        mem_iwait = 1'b0;
        tick();
        mem_iwait = 1'b1; mem_iload = 32'd0;
        #1;
        chk("refetch_ihit", {31'd0, dp_ihit}, 32'd1);
        chk("refetch_data", dp_imemload, 32'h33333333);
        hit_tick();
        counters("invfill");

        // asynchronous reset mid-fill
        dp_imemaddr = 32'h10;
        tick();
        chk("rstmid_memren", {31'd0, mem_iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rstmid_ihit", {31'd0, dp_ihit}, 32'd0);
        chk("rstmid_load", dp_imemload, 32'd0);
        chk("rstmid_memren0", {31'd0, mem_iREN}, 32'd0);
        chk("rstmid_iaddr", mem_iaddr, 32'd0);
        chk("rstmid_hits", hit_count, 32'd0);
        chk("rstmid_misses", miss_count, 32'd0);
        e_hit = 0; e_miss = 0;
        tick();
        nRST = 1'b1;
        #1;
        chk("rstmid_invalid", {31'd0, dp_ihit}, 32'd0);
        fill(32'h10, 32'h44444444, 0);
        hit_tick();
        counters("rstmid");

        // request dropped during FETCH still completes the fill
        dp_imemaddr = 32'h14;
        #1;
        chk("drop_miss", {31'd0, dp_ihit}, 32'd0);
        tick(); e_miss++;
        dp_iREN = 1'b0; dp_imemaddr = 32'h99;
        mem_iwait = 1'b0; mem_iload = 32'h55555555;
        #1;
        chk("drop_iaddr", mem_iaddr, 32'h14);
        tick();
        mem_iwait = 1'b1; mem_iload = 32'd0;
        #1;
        chk("drop_idle", {31'd0, mem_iREN}, 32'd0);
        chk("drop_noreq", {31'd0, dp_ihit}, 32'd0);
        dp_iREN = 1'b1; dp_imemaddr = 32'h14;
        #1;
        chk("drop_ihit", {31'd0, dp_ihit}, 32'd1);
        chk("drop_data", dp_imemload, 32'h55555555);
        hit_tick();
        counters("drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
